// File: rtl/execid_reorder_buffer.sv
// Reorder buffer for execid-tagged completions: releases entries in ascending id order once the watermark passes them.
// Optional checks: define EXECID_ROB_ASSERT_EN to enable immediate assertions on the producer/sink contract.
module execid_reorder_buffer #(
    parameter int WIDTH      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_id,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic [WIDTH-1:0]             wm,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_id,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]      ent_v;
    logic [WIDTH-1:0]      ent_id   [DEPTH];
    logic [DATA_WIDTH-1:0] ent_data [DEPTH];

    logic [OCC_W-1:0]      occ;
    logic [IDX_W-1:0]      free_idx;
    logic                  cand_found;
    logic [IDX_W-1:0]      cand_idx;
    logic [WIDTH-1:0]      cand_id;
    logic [DATA_WIDTH-1:0] cand_data;
    logic                  eligible;
    logic                  accept;
    logic                  load_out;

    // Occupancy and the lowest free slot come only from registered valid bits.
    always_comb begin
        occ      = '0;
        free_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ = occ + OCC_W'(ent_v[i]);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_v[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    // Strict less-than keeps the lowest index on equal ids.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        cand_id    = '0;
        cand_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_v[i] && (!cand_found || ent_id[i] < cand_id)) begin
                cand_found = 1'b1;
                cand_idx   = IDX_W'(i);
                cand_id    = ent_id[i];
                cand_data  = ent_data[i];
            end
        end
    end

    assign in_ready  = (occ < OCC_W'(DEPTH));
    assign occupancy = occ;
    assign eligible  = cand_found && (cand_id < wm);
    assign accept    = in_valid && in_ready;
    assign load_out  = eligible && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_id[i]   <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            if (load_out) begin
                ent_v[cand_idx] <= 1'b0;
            end
            if (accept) begin
                ent_v[free_idx]    <= 1'b1;
                ent_id[free_idx]   <= in_id;
                ent_data[free_idx] <= in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_id    <= '0;
            out_data  <= '0;
        end else if (!out_valid || out_ready) begin
            out_valid <= eligible;
            if (eligible) begin
                out_id   <= cand_id;
                out_data <= cand_data;
            end
        end
    end

`ifdef EXECID_ROB_ASSERT_EN
    logic [WIDTH-1:0] prev_wm;
    logic [WIDTH-1:0] prev_out_id;
    logic             have_prev_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_wm       <= '0;
            prev_out_id   <= '0;
            have_prev_out <= 1'b0;
        end else begin
            prev_wm <= wm;
            if (out_valid && out_ready) begin
                prev_out_id   <= out_id;
                have_prev_out <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (accept) begin
                assert (in_id >= wm) else begin
                    $display("execid_rob: in_id %h below watermark %h", in_id, wm);
                    $error("execid_rob: in_id below watermark");
                end
            end
            assert (wm >= prev_wm) else begin
                $display("execid_rob: watermark fell from %h to %h", prev_wm, wm);
                $error("execid_rob: watermark decreased");
            end
            if (out_valid && out_ready && have_prev_out) begin
                assert (out_id >= prev_out_id) else begin
                    $display("execid_rob: out_id %h after %h", out_id, prev_out_id);
                    $error("execid_rob: output order violated");
                end
            end
            assert (occ <= OCC_W'(DEPTH)) else begin
                $display("execid_rob: occupancy %0d exceeds depth", occ);
                $error("execid_rob: occupancy overflow");
            end
        end
    end
`endif

endmodule

// File: tb/tb_execid_reorder_buffer.sv
// Directed bench for execid_reorder_buffer (WIDTH=16, DATA_WIDTH=32, DEPTH=4) with hand-computed expectations.
module tb_execid_reorder_buffer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_id;
    logic [31:0] in_data;
    logic [15:0] wm;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_id;
    logic [31:0] out_data;
    logic [2:0]  occupancy;

    int compared;
    int mismatched;

    execid_reorder_buffer #(
        .WIDTH(16),
        .DATA_WIDTH(32),
        .DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_id(in_id),
        .in_data(in_data),
        .wm(wm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_id(out_id),
        .out_data(out_data),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; observations and new inputs happen 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] id, input logic [31:0] data);
        in_valid = v;
        in_id    = id;
        in_data  = data;
    endtask

    task automatic checkOut(input string tag, input logic v, input logic [15:0] id,
                            input logic [31:0] data, input logic [2:0] occ);
        checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'(v));
        if (v) begin
            checkOutput({tag, ".out_id"}, 64'(out_id), 64'(id));
            checkOutput({tag, ".out_data"}, 64'(out_data), 64'(data));
        end
        checkOutput({tag, ".occupancy"}, 64'(occupancy), 64'(occ));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 16'h0, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        out_ready  = 1'b1;
        wm         = 16'hFFFF;
        applyStimulus(1'b1, 16'h0005, 32'h5555);

        // Reset held with in_valid high
        tick();
        tick();
        checkOutput("rst.out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst.out_id", 64'(out_id), 64'd0);
        checkOutput("rst.out_data", 64'(out_data), 64'd0);
        checkOutput("rst.occupancy", 64'(occupancy), 64'd0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 16'h0, 32'h0);
        tick();
        checkOutput("rst.in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst.occ_after", 64'(occupancy), 64'd0);

        // Out-of-order ids held until the watermark moves
        do_reset();
        wm = 16'h0100;
        applyStimulus(1'b1, 16'h0103, 32'hA3);
        tick();
        applyStimulus(1'b1, 16'h0101, 32'hA1);
        tick();
        applyStimulus(1'b1, 16'h0102, 32'hA2);
        tick();
        applyStimulus(1'b0, 16'h0, 32'h0);
        tick();
        checkOut("t2.hold", 1'b0, 16'h0, 32'h0, 3'd3);
        wm = 16'h0200;
        tick();
        checkOut("t2.o1", 1'b1, 16'h0101, 32'hA1, 3'd2);
        tick();
        checkOut("t2.o2", 1'b1, 16'h0102, 32'hA2, 3'd1);
        tick();
        checkOut("t2.o3", 1'b1, 16'h0103, 32'hA3, 3'd0);
        tick();
        checkOut("t2.idle", 1'b0, 16'h0, 32'h0, 3'd0);

        // Full buffer, then drain one per cycle
        do_reset();
        wm = 16'h0001;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 16'h0010 + 16'(i), 32'hB0 + 32'(i));
            tick();
        end
        checkOutput("t3.in_ready_full", 64'(in_ready), 64'd0);
        checkOutput("t3.occ_full", 64'(occupancy), 64'd4);
        applyStimulus(1'b1, 16'h0020, 32'hBF);
        tick();
        checkOut("t3.no_accept", 1'b0, 16'h0, 32'h0, 3'd4);
        applyStimulus(1'b0, 16'h0, 32'h0);
        wm = 16'hFFFF;
        tick();
        checkOut("t3.r0", 1'b1, 16'h0010, 32'hB0, 3'd3);
        checkOutput("t3.in_ready_back", 64'(in_ready), 64'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            checkOut("t3.r", 1'b1, 16'h0010 + 16'(i), 32'hB0 + 32'(i), 3'(3 - i));
        end
        applyStimulus(1'b1, 16'hFFFF, 32'hFF);
        tick();
        applyStimulus(1'b0, 16'h0, 32'h0);
        tick();
        tick();
        checkOut("t3.allones", 1'b0, 16'h0, 32'h0, 3'd1);

        // Equal ids: lower slot wins
        do_reset();
        wm = 16'h0001;
        applyStimulus(1'b1, 16'h0002, 32'hC2);
        tick();
        applyStimulus(1'b1, 16'h0030, 32'hC3);
        tick();
        applyStimulus(1'b1, 16'h0005, 32'hBBBB);
        tick();
        applyStimulus(1'b0, 16'h0, 32'h0);
        wm = 16'h0003;
        tick();
        checkOut("t4.free0", 1'b1, 16'h0002, 32'hC2, 3'd2);
        applyStimulus(1'b1, 16'h0005, 32'hAAAA);
        tick();
        checkOut("t4.fill0", 1'b0, 16'h0, 32'h0, 3'd3);
        applyStimulus(1'b0, 16'h0, 32'h0);
        wm = 16'h0010;
        tick();
        checkOut("t4.first", 1'b1, 16'h0005, 32'hAAAA, 3'd2);
        tick();
        checkOut("t4.second", 1'b1, 16'h0005, 32'hBBBB, 3'd1);

        // Backpressure: output holds, buffer fills, resumes after out_ready
        do_reset();
        wm = 16'h0100;
        applyStimulus(1'b1, 16'h0010, 32'hD0);
        tick();
        checkOut("t5.lat", 1'b0, 16'h0, 32'h0, 3'd1);
        out_ready = 1'b0;
        for (int i = 1; i < 5; i++) begin
            applyStimulus(1'b1, 16'h0010 + 16'(i), 32'hD0 + 32'(i));
            tick();
            checkOut("t5.stall", 1'b1, 16'h0010, 32'hD0, 3'(i));
        end
        checkOutput("t5.in_ready_full", 64'(in_ready), 64'd0);
        applyStimulus(1'b1, 16'h0015, 32'hD5);
        out_ready = 1'b1;
        tick();
        checkOut("t5.resume", 1'b1, 16'h0011, 32'hD1, 3'd3);
        checkOutput("t5.in_ready", 64'(in_ready), 64'd1);
        applyStimulus(1'b0, 16'h0, 32'h0);
        for (int i = 2; i < 5; i++) begin
            tick();
            checkOut("t5.drain", 1'b1, 16'h0010 + 16'(i), 32'hD0 + 32'(i), 3'(4 - i));
        end
        tick();
        checkOut("t5.empty", 1'b0, 16'h0, 32'h0, 3'd0);

`ifndef EXECID_ROB_ASSERT_EN
        // Watermark contract broken: without checks the item simply flows through
        do_reset();
        wm = 16'h0004;
        applyStimulus(1'b1, 16'h0003, 32'hE3);
        tick();
        applyStimulus(1'b0, 16'h0, 32'h0);
        checkOut("t6.accept", 1'b0, 16'h0, 32'h0, 3'd1);
        tick();
        checkOut("t6.out", 1'b1, 16'h0003, 32'hE3, 3'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
